// File: rtl/clkgen_pkg.sv
// -----------------------------------------------------------------------------
// clkgen_pkg
// Shared definitions for the NCO clock-enable bank: configuration FSM state
// encoding, default parameter values and a channel-index width helper.
// -----------------------------------------------------------------------------
package clkgen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE
    } state_t;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_ACC_W       = 32;
    localparam int DEF_DUTY_W      = 8;
    localparam int DEF_LOCK_CYCLES = 16;

    // Width of a channel select; a single-channel bank still gets one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clkgen_nco_bank_if.sv
// -----------------------------------------------------------------------------
// clkgen_nco_bank_if
// Valid/ready configuration port of the NCO bank.
//   cfg_valid  master->slave  write request
//   cfg_ready  slave->master  bank can accept a write
//   cfg_ch     master->slave  target channel
//   cfg_inc    master->slave  phase increment
//   cfg_phase  master->slave  accumulator load value
//   cfg_duty   master->slave  outclk high-time fraction
// -----------------------------------------------------------------------------
interface clkgen_nco_bank_if
    import clkgen_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int DUTY_W = DEF_DUTY_W
);
    localparam int CH_W = ch_width(NUM_CH);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic [ACC_W-1:0]  cfg_phase;
    logic [DUTY_W-1:0] cfg_duty;

    modport master (
        output cfg_valid, cfg_ch, cfg_inc, cfg_phase, cfg_duty,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_inc, cfg_phase, cfg_duty,
        output cfg_ready
    );

endinterface

// File: rtl/clkgen_nco_ch.sv
// -----------------------------------------------------------------------------
// clkgen_nco_ch
// One NCO channel: phase accumulator with increment and duty registers.
//   clk, rst     clock and synchronous active-high reset
//   en           run enable; when low acc holds and tick/outclk are 0
//   load         one-cycle load strobe: takes load_inc/load_duty and sets
//                acc to load_phase instead of adding
//   tick         registered pulse, high the cycle after the accumulator wraps
//   outclk       registered level, high while the accumulator's top DUTY_W
//                bits are below duty
// -----------------------------------------------------------------------------
module clkgen_nco_ch #(
    parameter int ACC_W  = 32,
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [ACC_W-1:0]  load_inc,
    input  logic [ACC_W-1:0]  load_phase,
    input  logic [DUTY_W-1:0] load_duty,
    output logic              tick,
    output logic              outclk
);

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  inc;
    logic [DUTY_W-1:0] duty;
    logic [ACC_W:0]    sum;

    // Carry out of the extra top bit is the wrap indication.
    // NOTE: always_comb assigns every output on every path, so no latch forms.
    always_comb begin
        sum = {1'b0, acc} + {1'b0, inc};
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge
    // values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the few state registers here are all reset; reset values
            // are observable (outclk depends on acc and duty from reset on).
            acc    <= '0;
            inc    <= '0;
            duty   <= '0;
            tick   <= 1'b0;
            outclk <= 1'b0;
        end else if (load) begin
            // New settings take effect in the load cycle itself.
            inc    <= load_inc;
            duty   <= load_duty;
            acc    <= load_phase;
            tick   <= 1'b0;
            outclk <= en && (load_phase[ACC_W-1 -: DUTY_W] < load_duty);
        end else if (en) begin
            acc    <= sum[ACC_W-1:0];
            tick   <= sum[ACC_W];
            outclk <= (sum[ACC_W-1 -: DUTY_W] < duty);
        end else begin
            // Paused: acc holds so re-enabling resumes where it stopped.
            tick   <= 1'b0;
            outclk <= 1'b0;
        end
    end

endmodule

// File: rtl/clkgen_nco_bank.sv
// -----------------------------------------------------------------------------
// clkgen_nco_bank
// Bank of NUM_CH numerically-controlled oscillators producing clock enables.
//   refclk   sole clock, rising edge
//   rst      synchronous active-high reset
//   cfg      valid/ready configuration port (slave side)
//   ch_en    per-channel run enable
//   tick     per-channel one-cycle pulse on accumulator wrap
//   outclk   per-channel registered duty-controlled level
//   locked   high once the last accepted write has settled
// A write is accepted in IDLE, loads the target channel in LOAD, then waits
// LOCK_CYCLES cycles in SETTLE before locked reasserts. Writes to a channel
// index >= NUM_CH complete the handshake and are dropped.
// -----------------------------------------------------------------------------
module clkgen_nco_bank
    import clkgen_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int DUTY_W      = DEF_DUTY_W,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic                refclk,
    input  logic                rst,
    clkgen_nco_bank_if.slave    cfg,
    input  logic [NUM_CH-1:0]   ch_en,
    output logic [NUM_CH-1:0]   tick,
    output logic [NUM_CH-1:0]   outclk,
    output logic                locked
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int CNT_W = $clog2(LOCK_CYCLES) + 1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CH_W-1:0]   lat_ch;
    logic [ACC_W-1:0]  lat_inc;
    logic [ACC_W-1:0]  lat_phase;
    logic [DUTY_W-1:0] lat_duty;
    logic              ch_ok;

    assign ch_ok = int'(cfg.cfg_ch) < NUM_CH;

    // cfg_ready is registered: high exactly while the FSM sits in IDLE.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            locked        <= 1'b0;
            cfg.cfg_ready <= 1'b1;
            lat_ch        <= '0;
            lat_inc       <= '0;
            lat_phase     <= '0;
            lat_duty      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Out-of-range targets are acknowledged but ignored.
                    if (cfg.cfg_valid && ch_ok) begin
                        lat_ch        <= cfg.cfg_ch;
                        lat_inc       <= cfg.cfg_inc;
                        lat_phase     <= cfg.cfg_phase;
                        lat_duty      <= cfg.cfg_duty;
                        locked        <= 1'b0;
                        cfg.cfg_ready <= 1'b0;
                        state         <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt   <= '0;
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                        locked        <= 1'b1;
                        cfg.cfg_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    cfg.cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_load;

        assign ch_load = (state == ST_LOAD) && (lat_ch == CH_W'(i));

        clkgen_nco_ch #(
            .ACC_W  (ACC_W),
            .DUTY_W (DUTY_W)
        ) u_ch (
            .clk        (refclk),
            .rst        (rst),
            .en         (ch_en[i]),
            .load       (ch_load),
            .load_inc   (lat_inc),
            .load_phase (lat_phase),
            .load_duty  (lat_duty),
            .tick       (tick[i]),
            .outclk     (outclk[i])
        );
    end

endmodule

// File: tb/tb_clkgen_nco_bank.sv
// -----------------------------------------------------------------------------
// tb_clkgen_nco_bank
// Directed bench for clkgen_nco_bank. dut_a is a 4-channel bank, dut_b a
// 3-channel bank used for the out-of-range channel write. Edge index k counts
// rising edges from the first accepted write on dut_a; outputs are sampled
// 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_clkgen_nco_bank;

    logic refclk = 1'b0;
    logic rst    = 1'b1;

    always #5 refclk = ~refclk;

    clkgen_nco_bank_if #(.NUM_CH(4), .ACC_W(32), .DUTY_W(8)) cfg_a ();
    clkgen_nco_bank_if #(.NUM_CH(3), .ACC_W(32), .DUTY_W(8)) cfg_b ();

    logic [3:0] ch_en_a, tick_a, outclk_a;
    logic       locked_a;
    logic [2:0] ch_en_b, tick_b, outclk_b;
    logic       locked_b;

    clkgen_nco_bank #(
        .NUM_CH(4), .ACC_W(32), .DUTY_W(8), .LOCK_CYCLES(16)
    ) dut_a (
        .refclk (refclk),
        .rst    (rst),
        .cfg    (cfg_a),
        .ch_en  (ch_en_a),
        .tick   (tick_a),
        .outclk (outclk_a),
        .locked (locked_a)
    );

    clkgen_nco_bank #(
        .NUM_CH(3), .ACC_W(32), .DUTY_W(8), .LOCK_CYCLES(16)
    ) dut_b (
        .refclk (refclk),
        .rst    (rst),
        .cfg    (cfg_b),
        .ch_en  (ch_en_b),
        .tick   (tick_b),
        .outclk (outclk_b),
        .locked (locked_b)
    );

    int passed = 0;
    int total  = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    initial begin
        cfg_a.cfg_valid = 1'b0; cfg_a.cfg_ch = '0; cfg_a.cfg_inc = '0;
        cfg_a.cfg_phase = '0;   cfg_a.cfg_duty = '0;
        cfg_b.cfg_valid = 1'b0; cfg_b.cfg_ch = '0; cfg_b.cfg_inc = '0;
        cfg_b.cfg_phase = '0;   cfg_b.cfg_duty = '0;
        ch_en_a = '0;
        ch_en_b = '0;

        // ---------------- reset state ----------------
        step(3);
        check("rst_tick",   tick_a,          4'b0000);
        check("rst_outclk", outclk_a,        4'b0000);
        check("rst_locked", locked_a,        1'b0);
        check("rst_ready",  cfg_a.cfg_ready, 1'b1);
        check("rst_lock_b", locked_b,        1'b0);
        rst     = 1'b0;
        ch_en_a = 4'b1111;

        // ---------------- ch0: inc=2^30, phase 0, 50% ----------------
        cfg_a.cfg_valid = 1'b1;
        cfg_a.cfg_ch    = 2'd0;
        cfg_a.cfg_inc   = 32'h4000_0000;
        cfg_a.cfg_phase = 32'h0000_0000;
        cfg_a.cfg_duty  = 8'd128;
        step(1);                                   // k=0: accept edge
        check("acc_ready0",  cfg_a.cfg_ready, 1'b0);
        check("acc_locked0", locked_a,        1'b0);
        cfg_a.cfg_valid = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            step(1);
            check("t1_tick0",   tick_a[0],       (k >= 5) && (k % 4 == 1));
            check("t1_outclk0", outclk_a[0],     (k % 4 == 1) || (k % 4 == 2));
            check("t1_locked",  locked_a,        k == 17);
            check("t1_ready",   cfg_a.cfg_ready, k == 17);
        end

        // ---------------- ch1: inc=2^30, phase 2^31 ----------------
        step(2);                                   // k=19
        cfg_a.cfg_valid = 1'b1;
        cfg_a.cfg_ch    = 2'd1;
        cfg_a.cfg_inc   = 32'h4000_0000;
        cfg_a.cfg_phase = 32'h8000_0000;
        cfg_a.cfg_duty  = 8'd128;
        step(1);                                   // k=20: accept, load at 21
        cfg_a.cfg_valid = 1'b0;
        for (int k = 21; k <= 37; k++) begin
            step(1);
            check("t2_tick",   tick_a[1:0],
                  {(k > 21) && (k % 4 == 3), k % 4 == 1});
            check("t2_outclk", outclk_a[1:0],
                  {(k % 4 == 3) || (k % 4 == 0), (k % 4 == 1) || (k % 4 == 2)});
            check("t2_locked", locked_a,        k == 37);
            check("t2_ready",  cfg_a.cfg_ready, k == 37);
        end

        // ---------------- cfg_valid held for 40 cycles ----------------
        cfg_a.cfg_valid = 1'b1;
        cfg_a.cfg_ch    = 2'd2;
        cfg_a.cfg_inc   = '0;
        cfg_a.cfg_phase = '0;
        cfg_a.cfg_duty  = '0;
        for (int k = 38; k <= 77; k++) begin
            step(1);
            check("t3_ready",  cfg_a.cfg_ready, (k - 38) % 18 == 17);
            check("t3_locked", locked_a,        (k - 38) % 18 == 17);
        end
        cfg_a.cfg_valid = 1'b0;
        step(13);                                  // k=90
        check("t3_lock_pre", locked_a, 1'b0);
        step(1);                                   // k=91
        check("t3_lock_end", locked_a, 1'b1);

        // ---------------- ch0 paused for 5 cycles ----------------
        ch_en_a[0] = 1'b0;
        for (int k = 92; k <= 96; k++) begin
            step(1);
            check("t4_tick_off",   tick_a[0],   1'b0);
            check("t4_outclk_off", outclk_a[0], 1'b0);
            check("t4_acc_held",   dut_a.g_ch[0].u_ch.acc, 32'h8000_0000);
        end
        ch_en_a[0] = 1'b1;
        for (int k = 97; k <= 104; k++) begin
            step(1);
            check("t4_tick_on",   tick_a[0],   (k + 2) % 4 == 0);
            check("t4_outclk_on", outclk_a[0], (k + 2) % 4 < 2);
        end

        // ---------------- reset during SETTLE at cnt=7 ----------------
        cfg_a.cfg_valid = 1'b1;
        cfg_a.cfg_ch    = 2'd3;
        cfg_a.cfg_inc   = 32'h4000_0000;
        cfg_a.cfg_phase = '0;
        cfg_a.cfg_duty  = 8'd128;
        step(1);
        cfg_a.cfg_valid = 1'b0;
        step(8);
        check("t5_cnt7",    dut_a.cnt,       5'd7);
        check("t5_settle",  cfg_a.cfg_ready, 1'b0);
        rst = 1'b1;
        step(1);
        check("t5_tick",    tick_a,          4'b0000);
        check("t5_outclk",  outclk_a,        4'b0000);
        check("t5_locked",  locked_a,        1'b0);
        check("t5_ready",   cfg_a.cfg_ready, 1'b1);
        check("t5_inc0",    dut_a.g_ch[0].u_ch.inc, 32'h0);
        check("t5_inc3",    dut_a.g_ch[3].u_ch.inc, 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            check("t5_no_tick",   tick_a,   4'b0000);
            check("t5_no_outclk", outclk_a, 4'b0000);
            check("t5_stay_lock", locked_a, 1'b0);
        end

        // ---------------- NUM_CH=3, write to channel 3 ----------------
        ch_en_b = 3'b001;
        cfg_b.cfg_valid = 1'b1;
        cfg_b.cfg_ch    = 2'd0;
        cfg_b.cfg_inc   = 32'h4000_0000;
        cfg_b.cfg_phase = '0;
        cfg_b.cfg_duty  = 8'd128;
        step(1);                                   // j=0
        cfg_b.cfg_valid = 1'b0;
        step(17);                                  // j=17
        check("t6_lock_b",  locked_b,        1'b1);
        cfg_b.cfg_valid = 1'b1;
        cfg_b.cfg_ch    = 2'd3;
        cfg_b.cfg_inc   = 32'h8000_0000;
        cfg_b.cfg_duty  = 8'd255;
        step(1);                                   // j=18: dropped write
        check("t6_bad_ready",  cfg_b.cfg_ready, 1'b1);
        check("t6_bad_locked", locked_b,        1'b1);
        cfg_b.cfg_valid = 1'b0;
        for (int j = 19; j <= 26; j++) begin
            step(1);
            check("t6_tick0",   tick_b[0],       j % 4 == 1);
            check("t6_outclk0", outclk_b[0],     (j % 4 == 1) || (j % 4 == 2));
            check("t6_idle_ch", {tick_b[2:1], outclk_b[2:1]}, 4'b0000);
            check("t6_locked",  locked_b,        1'b1);
            check("t6_ready",   cfg_b.cfg_ready, 1'b1);
        end
        check("t6_inc0", dut_b.g_ch[0].u_ch.inc, 32'h4000_0000);
        check("t6_inc1", dut_b.g_ch[1].u_ch.inc, 32'h0);
        check("t6_inc2", dut_b.g_ch[2].u_ch.inc, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
